// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data ports and memory bus shared through one arbiter
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ack;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ack;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, mem_read, mem_write, mem_addr, mem_wdata, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_read, mem_write, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-fetch and D accesses onto one fixed-latency memory port
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_D_STREAK = 4
) (
    input logic                clk,
    input logic                reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [SW-1:0]        r_streak;
    logic                 r_owner;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic                 w_grant;
    logic                 w_pick_d;
    logic                 w_last;
    logic                 w_mem_read;
    logic                 w_mem_write;
    logic                 w_i_ack;
    logic                 w_d_ack;

    // D wins unless I has waited through a full streak of D grants
    assign w_grant  = (r_state == IDLE) && (bus.i_req || bus.d_req);
    assign w_pick_d = bus.d_req && !(bus.i_req && r_streak == SW'(MAX_D_STREAK));
    assign w_last   = r_cnt == CW'(MEM_LATENCY - 1);

    // state register; reset aborts any in-flight access without an ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next state, strobes and acks
    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_i_ack     = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            IDLE:    w_next = w_grant ? ACCESS : IDLE;
            ACCESS: begin
                w_mem_read  = !r_we;
                w_mem_write = r_we;
                w_next      = w_last ? ACK : ACCESS;
            end
            ACK: begin
                w_i_ack = !r_owner;
                w_d_ack = r_owner;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // latch the winner's request so later input changes cannot disturb the access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick_d;
            r_we    <= w_pick_d && bus.d_we;
            r_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
            r_wdata <= w_pick_d ? bus.d_wdata : r_wdata;
        end
    end

    // consecutive D grants taken while I was waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_streak <= '0;
        else if (w_grant) r_streak <= !(w_pick_d && bus.i_req) ? '0 :
                                      (r_streak == SW'(MAX_D_STREAK)) ? r_streak : r_streak + 1'b1;
    end

    // cycles the strobe has been held in the current access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               r_cnt <= '0;
        else if (r_state == ACCESS) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        else                        r_cnt <= '0;
    end

    // capture read data at the end of the last strobe cycle; writes leave d_rdata alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (r_state == ACCESS && w_last) begin
            if (!r_owner)  r_i_rdata <= bus.mem_rdata;
            else if (!r_we) r_d_rdata <= bus.mem_rdata;
        end
    end

    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.i_ack     = w_i_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors and corner sequences for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int L = 2;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rd_cnt = 0;
    logic [15:0] mem [0:1023];
    vec_t vecs [9];

    mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

    mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(L), .MAX_D_STREAK(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // memory model: read data is only valid once the strobe has been held L cycles
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[10'h010] <= 16'hBEEF;
            mem[10'h020] <= 16'hC0DE;
            mem[10'h030] <= 16'h0A0A;
            mem[10'h100] <= 16'h5555;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
        rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;
    end

    assign bus.mem_rdata = (bus.mem_read && rd_cnt == L - 1) ? mem[bus.mem_addr[9:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int cyc = 0;
        int strobes = 0;
        logic bad = 1'b0;
        logic other = 1'b0;
        logic got = 1'b0;
        logic [15:0] d_prev = bus.d_rdata;
        @(negedge clk);
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr;
        end
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                if (bus.mem_addr !== v.addr || bus.mem_write !== (v.is_d & v.we) ||
                    (bus.mem_write && bus.mem_wdata !== v.wdata)) bad = 1'b1;
            end
            if (v.is_d ? bus.i_ack : bus.d_ack) other = 1'b1;
            got = v.is_d ? bus.d_ack : bus.i_ack;
        end
        chk($sformatf("v%0d_latency", idx), cyc, L + 1);
        chk($sformatf("v%0d_strobe_cycles", idx), strobes, L);
        chk($sformatf("v%0d_strobe_addr_data", idx), {31'd0, bad}, 0);
        chk($sformatf("v%0d_wrong_ack", idx), {31'd0, other}, 0);
        chk($sformatf("v%0d_owner", idx), {31'd0, bus.owner}, {31'd0, v.is_d});
        if (!v.is_d) chk($sformatf("v%0d_i_rdata", idx), {16'd0, bus.i_rdata}, {16'd0, v.exp_rdata});
        else         chk($sformatf("v%0d_d_rdata", idx), {16'd0, bus.d_rdata}, {16'd0, v.we ? d_prev : v.exp_rdata});
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, t_d, t_i, n_ack, t_prev;
        logic [5:0] order;
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hC0DE};
        vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0A0A};
        vecs[5] = '{1'b1, 1'b1, 16'h0030, 16'hFFFF, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b1, 1'b1, 16'h0040, 16'h8001, 16'h0000};
        vecs[8] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h8001};
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_acks", {30'd0, bus.i_ack, bus.d_ack}, 0);
        chk("reset_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
        chk("reset_owner", {31'd0, bus.owner}, 0);
        chk("reset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        reset_n = 1'b1;

        for (int k = 0; k < 9; k++) run_txn(vecs[k], k);

        // simultaneous I and D: D first, I granted in the following IDLE
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h0020;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0100;
        cyc = 0; t_d = -1; t_i = -1;
        while (t_i < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.d_ack) begin
                t_d = cyc;
                bus.d_req = 1'b0;
                chk("t2_d_rdata", {16'd0, bus.d_rdata}, 32'h1234);
            end
            if (bus.i_ack) begin
                t_i = cyc;
                chk("t2_i_owner", {31'd0, bus.owner}, 0);
            end
        end
        bus.i_req = 1'b0;
        chk("t2_d_latency", t_d, L + 1);
        chk("t2_i_after_d", t_i - t_d, L + 2);
        chk("t2_i_rdata", {16'd0, bus.i_rdata}, 32'hC0DE);

        // both held continuously with streak limit 2: D,D,I,D,D,I
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
        order = 6'b011011;
        cyc = 0; n_ack = 0;
        while (n_ack < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.i_ack || bus.d_ack) begin
                chk($sformatf("t4_grant%0d_is_d", n_ack), {31'd0, bus.d_ack}, {31'd0, order[n_ack]});
                n_ack++;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("t4_grant_count", n_ack, 6);
        chk("t4_period_total", cyc, 6 * (L + 2) - 1);

        // I held through three fetches: acks exactly L+2 apart
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h0020;
        cyc = 0; n_ack = 0; t_prev = 0;
        while (n_ack < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.i_ack) begin
                if (n_ack > 0) chk($sformatf("t6_spacing%0d", n_ack), cyc - t_prev, L + 2);
                chk($sformatf("t6_rdata%0d", n_ack), {16'd0, bus.i_rdata}, 32'hC0DE);
                t_prev = cyc;
                n_ack++;
            end
        end
        bus.i_req = 1'b0;
        chk("t6_ack_count", n_ack, 3);

        // asynchronous reset in the middle of an access
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        @(negedge clk);
        chk("t5_in_access", {31'd0, bus.mem_read}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_strobes_cleared", {30'd0, bus.mem_read, bus.mem_write}, 0);
        chk("t5_acks_cleared", {30'd0, bus.i_ack, bus.d_ack}, 0);
        chk("t5_rdata_cleared", {bus.i_rdata, bus.d_rdata}, 0);
        bus.i_req = 1'b0;
        n_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) n_ack++;
        end
        chk("t5_no_ack_in_reset", n_ack, 0);
        reset_n = 1'b1;
        run_txn(vecs[0], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
